// File: rtl/frame_minmax_tracker.sv
// frame_minmax_tracker
// Groups an unsigned sample stream into frames of FRAME_LEN samples. For each
// frame it tracks the running maximum and minimum. When the optional macro
// FRAME_MINMAX_THRESH_EN is defined, it also counts the samples above, below
// and equal to a threshold. The frame result is presented on a valid/ready
// handshake, and input is stalled until the result has been taken.
// Optional feature macro: FRAME_MINMAX_THRESH_EN (threshold counters).
module frame_minmax_tracker #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [7:0]       above_cnt,
  output logic [7:0]       below_cnt,
  output logic [7:0]       equal_cnt
);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Unsigned magnitude comparison helpers
  function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b);
  endfunction

  function automatic logic f_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b);
  endfunction

  function automatic logic f_eq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a == b);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_n;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic             w_in_ready;
  logic             w_res_valid;
  logic             w_accept;
  logic             w_first;
  logic             w_last;

  // The handshake flags are decoded from the state only, so they never
  // depend on in_valid or res_ready.
  assign w_in_ready  = (r_state == ST_ACCUM);
  assign w_res_valid = (r_state == ST_RESULT);
  assign w_accept    = in_valid & w_in_ready;
  assign w_first     = (r_n == 8'd0);
  assign w_last      = (r_n == LAST_IDX);

  assign in_ready  = w_in_ready;
  assign res_valid = w_res_valid;
  assign max_out   = r_max;
  assign min_out   = r_min;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; clear overrides both handshakes
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept && w_last) begin
            w_state_nxt = ST_RESULT;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            w_state_nxt = ST_ACCUM;
          end else begin
            w_state_nxt = ST_RESULT;
          end
        end
        default: begin
          w_state_nxt = ST_ACCUM;
        end
      endcase
    end
  end

  // Sample index within the current frame; it wraps on the last sample
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_n <= 8'd0;
    end else if (clear) begin
      r_n <= 8'd0;
    end else if (w_accept) begin
      r_n <= w_last ? 8'd0 : (r_n + 8'd1);
    end
  end

  // Running extremes: the first sample loads both registers. A tie leaves a
  // register unchanged. Clear keeps the last extremes visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_max <= {WIDTH{1'b0}};
      r_min <= ALL_ONES;
    end else if (!clear && w_accept) begin
      if (w_first) begin
        r_max <= in_data;
        r_min <= in_data;
      end else begin
        if (f_gt(in_data, r_max)) begin
          r_max <= in_data;
        end
        if (f_lt(in_data, r_min)) begin
          r_min <= in_data;
        end
      end
    end
  end

`ifdef FRAME_MINMAX_THRESH_EN
  logic [7:0] r_above;
  logic [7:0] r_below;
  logic [7:0] r_equal;
  logic       w_th_gt;
  logic       w_th_lt;
  logic       w_th_eq;

  assign w_th_gt = f_gt(in_data, threshold);
  assign w_th_lt = f_lt(in_data, threshold);
  assign w_th_eq = f_eq(in_data, threshold);

  // Threshold counters. The first sample restarts them, and each later
  // sample bumps exactly one counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_above <= 8'd0;
      r_below <= 8'd0;
      r_equal <= 8'd0;
    end else if (clear) begin
      r_above <= 8'd0;
      r_below <= 8'd0;
      r_equal <= 8'd0;
    end else if (w_accept) begin
      if (w_first) begin
        r_above <= {7'd0, w_th_gt};
        r_below <= {7'd0, w_th_lt};
        r_equal <= {7'd0, w_th_eq};
      end else if (w_th_gt) begin
        r_above <= r_above + 8'd1;
      end else if (w_th_lt) begin
        r_below <= r_below + 8'd1;
      end else begin
        r_equal <= r_equal + 8'd1;
      end
    end
  end

  assign above_cnt = r_above;
  assign below_cnt = r_below;
  assign equal_cnt = r_equal;
`else
  // No comparator or counters are built, and the threshold port is ignored.
  logic w_unused_threshold;
  assign w_unused_threshold = ^threshold;
  assign above_cnt = 8'd0;
  assign below_cnt = 8'd0;
  assign equal_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Self-checking bench for frame_minmax_tracker. It drives a table of frames
// through a FRAME_LEN=4 instance and holds the expected results in a
// scoreboard queue. Hand-written sequences cover stall, clear, reset and the
// FRAME_LEN=1 instance.
module tb_frame_minmax_tracker;

  localparam bit THRESH_ON =
`ifdef FRAME_MINMAX_THRESH_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic [3:0][3:0] s;
    logic [3:0]      th;
    logic [3:0]      mx;
    logic [3:0]      mn;
    logic [7:0]      ab;
    logic [7:0]      bl;
    logic [7:0]      eq;
  } vec_t;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] mn;
    logic [7:0] ab;
    logic [7:0] bl;
    logic [7:0] eq;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic [3:0] threshold = 4'd0;
  logic in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic res_ready = 1'b0;
  logic in_ready, res_valid;
  logic [3:0] max_out, min_out;
  logic [7:0] above_cnt, below_cnt, equal_cnt;

  logic in_valid1 = 1'b0;
  logic [3:0] in_data1 = 4'd0;
  logic in_ready1, res_valid1;
  logic [3:0] max1, min1;
  logic [7:0] above1, below1, equal1;

  int n_tests = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  exp_t e_dump;
  vec_t tbl[6];

  always #5 clock = ~clock;

  frame_minmax_tracker #(.WIDTH(4), .FRAME_LEN(4)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .max_out(max_out), .min_out(min_out),
    .above_cnt(above_cnt), .below_cnt(below_cnt), .equal_cnt(equal_cnt)
  );

  frame_minmax_tracker #(.WIDTH(4), .FRAME_LEN(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(1'b0), .threshold(4'd8),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .res_valid(res_valid1), .res_ready(1'b1),
    .max_out(max1), .min_out(min1),
    .above_cnt(above1), .below_cnt(below1), .equal_cnt(equal1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3,
                              input logic [3:0] th, input logic [3:0] mx,
                              input logic [3:0] mn, input logic [7:0] ab,
                              input logic [7:0] bl, input logic [7:0] eq);
    vec_t v;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.th = th; v.mx = mx; v.mn = mn; v.ab = ab; v.bl = bl; v.eq = eq;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.mx = v.mx;
    e.mn = v.mn;
    e.ab = THRESH_ON ? v.ab : 8'd0;
    e.bl = THRESH_ON ? v.bl : 8'd0;
    e.eq = THRESH_ON ? v.eq : 8'd0;
    return e;
  endfunction

  // Scoreboard: compare when a result handshake is about to complete
  always @(negedge clock) begin : sb_mon
    exp_t e;
    if (reset_n && res_valid && res_ready && !clear) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: result max %0d min %0d with empty queue", max_out, min_out);
      end else begin
        e = sb_q.pop_front();
        check("sb_max", int'(max_out), int'(e.mx));
        check("sb_min", int'(min_out), int'(e.mn));
        check("sb_above", int'(above_cnt), int'(e.ab));
        check("sb_below", int'(below_cnt), int'(e.bl));
        check("sb_equal", int'(equal_cnt), int'(e.eq));
      end
    end
  end

  // Drive one frame back-to-back, starting at posedge+1; ends on the negedge
  // of the cycle after the last accept.
  task automatic run_frame(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = v.s[i];
      threshold = v.th;
      if (i == 3) sb_q.push_back(to_exp(v));
      @(negedge clock);
      check("in_ready_accum", int'(in_ready), 1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("lat_res_valid", int'(res_valid), 1);
    check("lat_in_ready", int'(in_ready), 0);
  endtask

  // Result taken at the next edge (res_ready already high), then in_ready returns
  task automatic turnaround();
    @(posedge clock); #1;
    @(negedge clock);
    check("turn_in_ready", int'(in_ready), 1);
    check("turn_res_valid", int'(res_valid), 0);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(4'd3, 4'd9, 4'd7, 4'd12, 4'd7, 4'd12, 4'd3, 8'd2, 8'd1, 8'd1);
    tbl[1] = mk(4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 8'd0, 8'd0, 8'd4);
    tbl[2] = mk(4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 8'd2, 8'd0, 8'd2);
    tbl[3] = mk(4'd8, 4'd4, 4'd10, 4'd1, 4'd15, 4'd10, 4'd1, 8'd0, 8'd4, 8'd0);
    tbl[4] = mk(4'd15, 4'd15, 4'd14, 4'd15, 4'd14, 4'd15, 4'd14, 8'd3, 8'd0, 8'd1);
    tbl[5] = mk(4'd15, 4'd0, 4'd1, 4'd2, 4'd7, 4'd15, 4'd0, 8'd1, 8'd3, 8'd0);

    // Reset state
    @(posedge clock); @(posedge clock); #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_max", int'(max_out), 0);
    check("rst_min", int'(min_out), 15);
    check("rst_cnt_sum", int'(above_cnt) + int'(below_cnt) + int'(equal_cnt), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table frames with res_ready held high
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_frame(tbl[k]);
      turnaround();
    end

    // Stall in RESULT with in_valid high and data 15
    res_ready = 1'b0;
    run_frame(tbl[0]);
    in_valid = 1'b1;
    in_data = 4'd15;
    threshold = 4'd7;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
        @(negedge clock);
      end
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_res_valid", int'(res_valid), 1);
      check("stall_max", int'(max_out), 12);
      check("stall_min", int'(min_out), 3);
    end
    @(posedge clock); #1;
    res_ready = 1'b1;
    @(posedge clock); #1;
    run_frame(tbl[5]);
    turnaround();

    // Clear after two samples, plus a clear that coincides with an accept
    in_valid = 1'b1; in_data = 4'd1; threshold = 4'd7;
    @(posedge clock); #1;
    in_data = 4'd14;
    @(posedge clock); #1;
    clear = 1'b1; in_data = 4'd0;
    @(posedge clock); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("clr_cnt_sum", int'(above_cnt) + int'(below_cnt) + int'(equal_cnt), 0);
    check("clr_max_kept", int'(max_out), 14);
    check("clr_min_kept", int'(min_out), 1);
    check("clr_in_ready", int'(in_ready), 1);
    @(posedge clock); #1;
    run_frame(mk(4'd6, 4'd2, 4'd8, 4'd4, 4'd7, 4'd8, 4'd2, 8'd1, 8'd3, 8'd0));
    turnaround();

    // Clear while in RESULT
    res_ready = 1'b0;
    run_frame(tbl[1]);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    check("clrres_res_valid", int'(res_valid), 0);
    check("clrres_in_ready", int'(in_ready), 1);
    check("clrres_max", int'(max_out), 5);
    check("clrres_min", int'(min_out), 5);
    check("clrres_cnt_sum", int'(above_cnt) + int'(below_cnt) + int'(equal_cnt), 0);
    e_dump = sb_q.pop_back();
    @(posedge clock); #1;

    // Asynchronous reset while in RESULT
    run_frame(tbl[2]);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_max", int'(max_out), 0);
    check("arst_min", int'(min_out), 15);
    check("arst_cnt_sum", int'(above_cnt) + int'(below_cnt) + int'(equal_cnt), 0);
    reset_n = 1'b1;
    e_dump = sb_q.pop_back();
    @(posedge clock); #1;
    res_ready = 1'b1;

    // FRAME_LEN=1: every sample is its own frame
    for (int k = 0; k < 4; k++) begin
      logic [3:0] v;
      v = (k == 0) ? 4'd0 : (k == 1) ? 4'd15 : (k == 2) ? 4'd8 : 4'd3;
      in_valid1 = 1'b1;
      in_data1 = v;
      @(posedge clock); #1;
      in_valid1 = 1'b0;
      @(negedge clock);
      check("f1_res_valid", int'(res_valid1), 1);
      check("f1_in_ready", int'(in_ready1), 0);
      check("f1_max", int'(max1), int'(v));
      check("f1_min", int'(min1), int'(v));
      check("f1_above", int'(above1), (THRESH_ON && v > 4'd8) ? 1 : 0);
      check("f1_below", int'(below1), (THRESH_ON && v < 4'd8) ? 1 : 0);
      check("f1_equal", int'(equal1), (THRESH_ON && v == 4'd8) ? 1 : 0);
      @(posedge clock); #1;
      @(negedge clock);
      check("f1_turn_in_ready", int'(in_ready1), 1);
      @(posedge clock); #1;
    end

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
